// File: rtl/pe_array_ws_ctrl.sv
// Weight-stationary ROWS x COLS signed MAC array with input skew, output
// de-skew, valid/ready handshakes and a shadow/active weight bank FSM.
module pe_array_ws_ctrl #(
    parameter int ROWS   = 32,
    parameter int COLS   = 16,
    parameter int DATA_W = 8,
    parameter int ACC_W  = 32
) (
    input  logic                     CLK,
    input  logic                     RESET,
    input  logic                     w_valid,
    output logic                     w_ready,
    input  logic [COLS*DATA_W-1:0]   w_data,
    input  logic                     w_commit,
    output logic                     w_loaded,
    input  logic                     a_valid,
    output logic                     a_ready,
    input  logic [ROWS*DATA_W-1:0]   a_data,
    output logic                     out_valid,
    output logic [COLS*ACC_W-1:0]    out_sum,
    output logic                     busy
);

    localparam int L     = ROWS + COLS - 1;
    localparam int CNT_W = $clog2(ROWS + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_LOADED,
        S_DRAIN,
        S_SWAP
    } state_t;

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   cnt, cnt_nxt;
    logic [L-1:0]       vpipe;
    logic               w_acc, a_acc, swap_en;

    logic signed [DATA_W-1:0] shadow  [ROWS][COLS];
    logic signed [DATA_W-1:0] active  [ROWS][COLS];
    logic signed [DATA_W-1:0] a_in    [ROWS];
    logic signed [DATA_W-1:0] row_act [ROWS];
    logic signed [DATA_W-1:0] act_in  [ROWS][COLS];
    logic signed [DATA_W-1:0] act_q   [ROWS][COLS];
    logic signed [ACC_W-1:0]  psum_in [ROWS][COLS];
    logic signed [ACC_W-1:0]  prod    [ROWS][COLS];
    logic signed [ACC_W-1:0]  psum_q  [ROWS][COLS];
    logic signed [ACC_W-1:0]  col_out [COLS];
    logic [COLS*ACC_W-1:0]    col_flat, held;

    assign w_acc = w_valid & w_ready;
    assign a_acc = a_valid & a_ready;

    // State register and beat counter
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            state <= S_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Next-state: commit is only honoured once a full set is loaded
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        unique case (state)
            S_IDLE: begin
                if (w_acc) begin
                    state_nxt = S_LOAD;
                    cnt_nxt   = CNT_W'(1);
                end
            end
            S_LOAD: begin
                if (w_acc) begin
                    cnt_nxt = cnt + 1'b1;
                    if (cnt_nxt == CNT_W'(ROWS)) state_nxt = S_LOADED;
                end
            end
            S_LOADED: if (w_commit) state_nxt = S_DRAIN;
            S_DRAIN:  if (vpipe == '0) state_nxt = S_SWAP;
            S_SWAP:   state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    // Handshake and status outputs decoded from state
    always_comb begin
        w_ready  = (state == S_IDLE) || (state == S_LOAD);
        a_ready  = (state == S_IDLE) || (state == S_LOAD) ||
                   (state == S_LOADED);
        w_loaded = (state == S_LOADED) || (state == S_DRAIN);
        swap_en  = (state == S_SWAP);
        busy     = (vpipe != '0) || (state == S_LOAD) ||
                   (state == S_DRAIN) || (state == S_SWAP);
    end

    // Shadow shift chain fills from row 0; active copies it on swap
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            for (int r = 0; r < ROWS; r++)
                for (int c = 0; c < COLS; c++) begin
                    shadow[r][c] <= '0;
                    active[r][c] <= '0;
                end
        end else begin
            if (w_acc) begin
                for (int c = 0; c < COLS; c++)
                    shadow[0][c] <= w_data[c*DATA_W +: DATA_W];
                for (int r = 1; r < ROWS; r++)
                    shadow[r] <= shadow[r-1];
            end
            if (swap_en) active <= shadow;
        end
    end

    // Input skew: row r delayed r cycles, bubbles inject zero
    for (genvar r = 0; r < ROWS; r++) begin : g_skew
        assign a_in[r] = a_acc ? a_data[r*DATA_W +: DATA_W] : '0;
        if (r == 0) begin : g_thru
            assign row_act[r] = a_in[r];
        end else begin : g_dly
            logic signed [DATA_W-1:0] sk [r];
            // Per-row delay line
            always_ff @(posedge CLK) begin
                if (!RESET) begin
                    for (int k = 0; k < r; k++) sk[k] <= '0;
                end else begin
                    sk[0] <= a_in[r];
                    for (int k = 1; k < r; k++) sk[k] <= sk[k-1];
                end
            end
            assign row_act[r] = sk[r-1];
        end
    end

    // PE interconnect: activations move right, sums move down
    always_comb begin
        for (int r = 0; r < ROWS; r++) begin
            act_in[r][0] = row_act[r];
            for (int c = 1; c < COLS; c++)
                act_in[r][c] = act_q[r][c-1];
        end
        for (int c = 0; c < COLS; c++) begin
            psum_in[0][c] = '0;
            for (int r = 1; r < ROWS; r++)
                psum_in[r][c] = psum_q[r-1][c];
        end
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                prod[r][c] = ACC_W'(act_in[r][c]) * ACC_W'(active[r][c]);
    end

    // PE registers: wrapping signed multiply-accumulate
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            for (int r = 0; r < ROWS; r++)
                for (int c = 0; c < COLS; c++) begin
                    act_q[r][c]  <= '0;
                    psum_q[r][c] <= '0;
                end
        end else begin
            for (int r = 0; r < ROWS; r++)
                for (int c = 0; c < COLS; c++) begin
                    act_q[r][c]  <= act_in[r][c];
                    psum_q[r][c] <= psum_in[r][c] + prod[r][c];
                end
        end
    end

    // Output de-skew: column c delayed so all columns align with the last
    for (genvar c = 0; c < COLS; c++) begin : g_dsk
        localparam int D = COLS - 1 - c;
        if (D == 0) begin : g_thru
            assign col_out[c] = psum_q[ROWS-1][c];
        end else begin : g_dly
            logic signed [ACC_W-1:0] ds [D];
            // Per-column delay line
            always_ff @(posedge CLK) begin
                if (!RESET) begin
                    for (int k = 0; k < D; k++) ds[k] <= '0;
                end else begin
                    ds[0] <= psum_q[ROWS-1][c];
                    for (int k = 1; k < D; k++) ds[k] <= ds[k-1];
                end
            end
            assign col_out[c] = ds[D-1];
        end
    end

    // Valid pipe tracks each accepted vector through the array
    always_ff @(posedge CLK) begin
        if (!RESET) vpipe <= '0;
        else        vpipe <= {vpipe[L-2:0], a_acc};
    end

    assign out_valid = vpipe[L-1];

    // Flatten aligned column sums
    always_comb begin
        col_flat = '0;
        for (int c = 0; c < COLS; c++)
            col_flat[c*ACC_W +: ACC_W] = col_out[c];
    end

    // Hold the last emitted result between pulses
    always_ff @(posedge CLK) begin
        if (!RESET)         held <= '0;
        else if (out_valid) held <= col_flat;
    end

    assign out_sum = out_valid ? col_flat : held;

endmodule

// File: tb/tb_pe_array_ws_ctrl.sv
// Directed bench for pe_array_ws_ctrl: a 2x2 instance for control and
// datapath scenarios, a 4x2 16-bit accumulator instance for wraparound.
module tb_pe_array_ws_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    int   errors = 0;
    int   checks = 0;

    logic        p_wv, p_wr, p_wc, p_ld, p_av, p_ar, p_ov, p_bz;
    logic [15:0] p_wd, p_ad;
    logic [63:0] p_os;

    logic        q_wv, q_wr, q_wc, q_ld, q_av, q_ar, q_ov, q_bz;
    logic [15:0] q_wd;
    logic [31:0] q_ad, q_os;

    pe_array_ws_ctrl #(
        .ROWS(2), .COLS(2), .DATA_W(8), .ACC_W(32)
    ) dut (
        .CLK(clk), .RESET(rst_n),
        .w_valid(p_wv), .w_ready(p_wr), .w_data(p_wd),
        .w_commit(p_wc), .w_loaded(p_ld),
        .a_valid(p_av), .a_ready(p_ar), .a_data(p_ad),
        .out_valid(p_ov), .out_sum(p_os), .busy(p_bz)
    );

    pe_array_ws_ctrl #(
        .ROWS(4), .COLS(2), .DATA_W(8), .ACC_W(16)
    ) dut_ovf (
        .CLK(clk), .RESET(rst_n),
        .w_valid(q_wv), .w_ready(q_wr), .w_data(q_wd),
        .w_commit(q_wc), .w_loaded(q_ld),
        .a_valid(q_av), .a_ready(q_ar), .a_data(q_ad),
        .out_valid(q_ov), .out_sum(q_os), .busy(q_bz)
    );

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            p_wv = 1'($urandom); p_wc = 1'($urandom);
            p_av = 1'($urandom); p_wd = 16'($urandom);
            p_ad = 16'($urandom);
            q_wv = 1'($urandom); q_wc = 1'($urandom);
            q_av = 1'($urandom); q_wd = 16'($urandom);
            q_ad = $urandom;
            cyc();
        end
        checks++; if (p_wr !== 1'b1) begin errors++; $display("FAIL rst_w_ready got=%b want=1", p_wr); end
        checks++; if (p_ar !== 1'b1) begin errors++; $display("FAIL rst_a_ready got=%b want=1", p_ar); end
        checks++; if (p_ld !== 1'b0) begin errors++; $display("FAIL rst_w_loaded got=%b want=0", p_ld); end
        checks++; if (p_ov !== 1'b0) begin errors++; $display("FAIL rst_out_valid got=%b want=0", p_ov); end
        checks++; if (p_os !== 64'h0) begin errors++; $display("FAIL rst_out_sum got=%h want=0", p_os); end
        checks++; if (p_bz !== 1'b0) begin errors++; $display("FAIL rst_busy got=%b want=0", p_bz); end
        checks++; if ({q_ov, q_bz, q_ld, q_os} !== 35'h0) begin errors++; $display("FAIL rst_ovf_outs got=%b%b%b %h want=0", q_ov, q_bz, q_ld, q_os); end
        p_wv = 0; p_wc = 0; p_av = 0; p_wd = '0; p_ad = '0;
        q_wv = 0; q_wc = 0; q_av = 0; q_wd = '0; q_ad = '0;
        rst_n = 1'b1;
        cyc();
        checks++; if ({p_wr, p_ar} !== 2'b11) begin errors++; $display("FAIL rst_release_ready got=%b want=11", {p_wr, p_ar}); end
    endtask

    task automatic test_load_commit();
        p_wc = 1; cyc(); p_wc = 0;
        checks++; if ({p_bz, p_ld, p_wr} !== 3'b001) begin errors++; $display("FAIL commit_idle_ignored got=%b want=001", {p_bz, p_ld, p_wr}); end
        p_wv = 1; p_wd = {8'd2, 8'd1}; cyc(); p_wv = 0;
        checks++; if ({p_ld, p_bz, p_wr} !== 3'b011) begin errors++; $display("FAIL load_state got=%b want=011", {p_ld, p_bz, p_wr}); end
        p_wc = 1; cyc(); p_wc = 0;
        checks++; if ({p_ld, p_bz, p_wr} !== 3'b011) begin errors++; $display("FAIL commit_load_ignored got=%b want=011", {p_ld, p_bz, p_wr}); end
        p_wv = 1; p_wd = {8'd4, 8'd3}; cyc(); p_wv = 0;
        checks++; if ({p_ld, p_bz, p_wr, p_ar} !== 4'b1001) begin errors++; $display("FAIL loaded_state got=%b want=1001", {p_ld, p_bz, p_wr, p_ar}); end
        p_wc = 1; cyc(); p_wc = 0;
        checks++; if ({p_ld, p_bz, p_ar, p_wr} !== 4'b1100) begin errors++; $display("FAIL drain_state got=%b want=1100", {p_ld, p_bz, p_ar, p_wr}); end
        cyc();
        checks++; if ({p_ld, p_bz, p_ar} !== 3'b010) begin errors++; $display("FAIL swap_state got=%b want=010", {p_ld, p_bz, p_ar}); end
        cyc();
        checks++; if ({p_ld, p_bz, p_ar, p_wr} !== 4'b0011) begin errors++; $display("FAIL idle_after_swap got=%b want=0011", {p_ld, p_bz, p_ar, p_wr}); end
        p_av = 1; p_ad = {8'hFA, 8'h05}; cyc(); p_av = 0;
        checks++; if (p_ov !== 1'b0) begin errors++; $display("FAIL lat_early0 got=%b want=0", p_ov); end
        cyc();
        checks++; if (p_ov !== 1'b0) begin errors++; $display("FAIL lat_early1 got=%b want=0", p_ov); end
        cyc();
        checks++; if (p_ov !== 1'b1) begin errors++; $display("FAIL lat_valid got=%b want=1", p_ov); end
        checks++; if (p_os !== {32'd8, 32'd9}) begin errors++; $display("FAIL first_sum got=%h want=%h", p_os, {32'd8, 32'd9}); end
        cyc();
        checks++; if ({p_ov, p_os} !== {1'b0, 32'd8, 32'd9}) begin errors++; $display("FAIL sum_hold got=%b %h want=0 %h", p_ov, p_os, {32'd8, 32'd9}); end
    endtask

    task automatic test_streaming();
        logic [15:0] vin [7];
        logic        avin [7];
        int          e0 [6];
        int          e1 [6];
        logic        eov;
        int          k;
        vin  = '{{8'd1, 8'd1}, {8'hFF, 8'd2}, {8'd4, 8'hFD}, {8'h80, 8'h7F},
                 16'h0, {8'd7, 8'd0}, {8'hFF, 8'hFF}};
        avin = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
        e0   = '{4, 5, -5, 253, 7, -4};
        e1   = '{6, 6, -4, 252, 14, -6};
        k = 0;
        for (int i = 0; i < 12; i++) begin
            p_av = (i < 7) ? avin[i] : 1'b0;
            p_ad = (i < 7) ? vin[i] : 16'h0;
            cyc();
            eov = (i >= 2 && i < 9) ? avin[i-2] : 1'b0;
            checks++; if (p_ov !== eov) begin errors++; $display("FAIL stream_valid cyc=%0d got=%b want=%b", i, p_ov, eov); end
            if (p_ov && eov && k < 6) begin
                checks++;
                if ($signed(p_os[31:0]) !== e0[k] || $signed(p_os[63:32]) !== e1[k]) begin
                    errors++;
                    $display("FAIL stream_sum%0d got=%0d,%0d want=%0d,%0d", k, $signed(p_os[31:0]), $signed(p_os[63:32]), e0[k], e1[k]);
                end
                k++;
            end
            if (i == 6) begin
                checks++;
                if ($signed(p_os[31:0]) !== e0[3] || $signed(p_os[63:32]) !== e1[3]) begin
                    errors++;
                    $display("FAIL stream_bubble_hold got=%h want=%0d,%0d", p_os, e0[3], e1[3]);
                end
            end
        end
        p_av = 0;
        checks++; if (k !== 6) begin errors++; $display("FAIL stream_count got=%0d want=6", k); end
    endtask

    task automatic test_overlapped();
        logic [15:0] vin [3];
        int          e0 [4];
        int          e1 [4];
        int          got;
        logic        sent, pre;
        vin = '{{8'd2, 8'd1}, {8'd3, 8'd2}, {8'd1, 8'd3}};
        e0  = '{5, 9, 10, -2};
        e1  = '{8, 14, 14, 20};
        got = 0; sent = 0;
        for (int i = 0; i < 30 && got < 4; i++) begin
            p_wv = (i < 2);
            p_wd = (i == 0) ? {8'd0, 8'd2} : {8'd5, 8'hFF};
            p_wc = (i == 2);
            p_av = (i < 3) ? 1'b1 : !sent;
            p_ad = (i < 3) ? vin[i] : {8'd1, 8'd4};
            pre  = p_ar;
            if (i == 3) begin
                checks++; if (pre !== 1'b0) begin errors++; $display("FAIL drain_blocks_a got=%b want=0", pre); end
            end
            cyc();
            if (i >= 3 && !sent && pre) begin
                sent = 1;
                checks++; if (got !== 3) begin errors++; $display("FAIL swap_order got=%0d want=3", got); end
            end
            if (p_ov) begin
                if (got < 4) begin
                    checks++;
                    if ($signed(p_os[31:0]) !== e0[got] || $signed(p_os[63:32]) !== e1[got]) begin
                        errors++;
                        $display("FAIL overlap_sum%0d got=%0d,%0d want=%0d,%0d", got, $signed(p_os[31:0]), $signed(p_os[63:32]), e0[got], e1[got]);
                    end
                end
                got++;
            end
        end
        p_av = 0; p_wv = 0; p_wc = 0;
        checks++; if (got !== 4 || !sent) begin errors++; $display("FAIL overlap_count got=%0d sent=%b want=4 1", got, sent); end
    endtask

    task automatic test_overflow();
        int got;
        q_wv = 1; q_wd = 16'h8080;
        repeat (4) cyc();
        q_wv = 0;
        checks++; if (q_ld !== 1'b1) begin errors++; $display("FAIL ovf_loaded got=%b want=1", q_ld); end
        q_wc = 1; cyc(); q_wc = 0;
        for (int i = 0; i < 10 && !(q_ar && !q_bz); i++) cyc();
        checks++; if ({q_ar, q_bz, q_ld} !== 3'b100) begin errors++; $display("FAIL ovf_swap_done got=%b want=100", {q_ar, q_bz, q_ld}); end
        q_av = 1; q_ad = 32'h80808080; cyc();
        q_ad = 32'h00808080; cyc();
        q_av = 0;
        got = 0;
        for (int i = 0; i < 12; i++) begin
            cyc();
            if (q_ov) begin
                checks++;
                if (q_os !== ((got == 0) ? 32'h0000_0000 : 32'hC000_C000)) begin
                    errors++;
                    $display("FAIL ovf_sum%0d got=%h want=%h", got, q_os, (got == 0) ? 32'h0 : 32'hC000C000);
                end
                got++;
            end
        end
        checks++; if (got !== 2) begin errors++; $display("FAIL ovf_count got=%0d want=2", got); end
    endtask

    task automatic test_reset_mid();
        int   hits;
        logic seen;
        p_wv = 1; p_wd = 16'h0101; p_av = 1; p_ad = {8'd1, 8'd1}; cyc();
        p_wv = 0; cyc();
        p_av = 0; rst_n = 1'b0; cyc(); rst_n = 1'b1;
        checks++; if ({p_ov, p_ld, p_bz, p_os} !== 67'h0) begin errors++; $display("FAIL midrst_outs got=%b%b%b %h want=0", p_ov, p_ld, p_bz, p_os); end
        hits = 0;
        for (int i = 0; i < 6; i++) begin
            cyc();
            if (p_ov) hits++;
        end
        checks++; if (hits !== 0) begin errors++; $display("FAIL midrst_no_valid got=%0d want=0", hits); end
        checks++; if ({p_wr, p_ld} !== 2'b10) begin errors++; $display("FAIL midrst_state got=%b want=10", {p_wr, p_ld}); end
        p_av = 1; p_ad = {8'd9, 8'd7}; cyc(); p_av = 0;
        seen = 0;
        for (int i = 0; i < 6 && !seen; i++) begin
            cyc();
            seen = p_ov;
        end
        checks++; if (!seen || p_os !== 64'h0) begin errors++; $display("FAIL midrst_zero_w got=%b %h want=1 0", seen, p_os); end
    endtask

    initial begin
        p_wv = 0; p_wc = 0; p_av = 0; p_wd = '0; p_ad = '0;
        q_wv = 0; q_wc = 0; q_av = 0; q_wd = '0; q_ad = '0;
        rst_n = 1'b0;
        test_reset();
        test_load_commit();
        test_streaming();
        test_overlapped();
        test_overflow();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/pe_array_ws_ctrl.md
Name: pe_array_ws_ctrl

Overview:
- Next-generation weight-stationary systolic array: ROWS x COLS signed MAC grid, activations enter from the left and partial sums flow down.
- Adds what the previous array lacked: parametrised data/accumulator widths, an internal input skew and output de-skew, valid/ready handshakes, and double-buffered (shadow/active) weights with a load/commit FSM.
- Sits between the activation/weight buffers and the accumulator/requant stage.

Parameters:
- ROWS, 32, PE rows (one activation lane per row); must be >=2.
- COLS, 16, PE columns (one output sum per column); must be >=2.
- DATA_W, 8, signed activation and weight width.
- ACC_W, 32, signed partial-sum width; must be >= 2*DATA_W.

Ports:
- CLK  in  1  clock, all logic on rising edge.
- RESET  in  1  synchronous, active-low reset.
- w_valid  in  1  weight beat valid.
- w_ready  out  1  weight beat accepted when w_valid&w_ready.
- w_data  in  COLS*DATA_W  one row of weights; column c at bits [c*DATA_W +: DATA_W].
- w_commit  in  1  request swap of shadow weights to active.
- w_loaded  out  1  high while shadow bank holds a complete, uncommitted set.
- a_valid  in  1  activation vector valid.
- a_ready  out  1  activation accepted when a_valid&a_ready.
- a_data  in  ROWS*DATA_W  row r activation at [r*DATA_W +: DATA_W].
- out_valid  out  1  aligned result valid (one-cycle pulse per accepted vector).
- out_sum  out  COLS*ACC_W  column c sum at [c*ACC_W +: ACC_W].
- busy  out  1  any activation in flight or FSM not in IDLE/LOADED.

Behaviour:
- Reset (RESET=0 at an edge):
  - Clears all shadow and active weights, skew/de-skew and PE registers, the valid pipe and the beat counter to 0; FSM enters IDLE.
  - Outputs: w_ready=1, a_ready=1, w_loaded=0, out_valid=0, out_sum=0, busy=0.
  - Reset mid-load or mid-compute discards everything; no partial result is emitted.
- FSM states IDLE, LOAD, LOADED, DRAIN, SWAP:
  - IDLE: w_ready=1. An accepted beat goes to LOAD with count=1.
  - LOAD: w_ready=1. Each accepted beat increments count. When count reaches ROWS it goes to LOADED.
  - Shadow bank is a shift chain: each beat enters shadow row 0 and rows shift down, so beat k ends in row ROWS-1-k.
  - LOADED: w_ready=0, w_loaded=1. w_commit=1 goes to DRAIN.
  - w_commit in IDLE or LOAD is ignored (no error, no state change).
  - DRAIN: a_ready=0. Waits until the valid pipe is empty (includes a vector accepted in the same cycle as w_commit), then goes to SWAP.
  - SWAP: one cycle. Active <= shadow, w_loaded=0, a_ready=0. Then IDLE.
  - Shadow loading in IDLE/LOAD runs concurrently with compute on the active weights.
- a_ready=1 in IDLE, LOAD and LOADED.
- Input skew:
  - Row r activation is delayed r cycles.
  - A non-accepted cycle injects activation 0, so bubbles add nothing.
- PE, registered every cycle:
  - act_out <= act_in.
  - psum_out <= psum_in + sext(act_in)*sext(w_active).
  - Row 0 psum_in=0.
  - Arithmetic is signed and wraps modulo 2^ACC_W.
- Output de-skew:
  - Column c bottom sum is delayed COLS-1-c cycles.
  - Result latency L = ROWS+COLS-1 cycles: vector accepted at edge t gives out_valid at edge t+L.
  - Back-to-back vectors give back-to-back results; throughput is 1 vector/cycle.
- out_valid is an L-deep shift of accept.
- out_sum holds its last value when out_valid=0 and is only meaningful with out_valid.
- No output backpressure; the consumer must accept every pulse.
- busy = (valid pipe nonzero) | state in {LOAD, DRAIN, SWAP}.

Test Plan:
- Reset: ROWS=2, COLS=2, DATA_W=8, ACC_W=32, drive random inputs with RESET=0 -> all outputs at reset values; the first cycle after release has w_ready=1, a_ready=1.
- Load/commit:
  - Load beats [w00=1,w01=2] then [w10=3,w11=4] (beat 0 lands in row 1), pulse commit -> DRAIN, SWAP, IDLE; w_loaded falls at SWAP.
  - Then a=[row0=5, row1=-6] -> after L=3 cycles, out_sum col0=5*3+(-6)*1=9, col1=5*4+(-6)*2=8.
- Streaming: 4 back-to-back vectors, then a bubble, then 2 vectors -> 6 out_valid pulses with identical 1-cycle spacing and a gap at the bubble; each matches the golden model.
- Overlapped load: load new shadow weights while streaming; commit while a vector is in flight -> a_ready=0 until its result emits. Results before the swap use old weights and results after use new ones; no vector is mixed.
- Overflow: DATA_W=8, ACC_W=16, ROWS=4, all a=-128, w=-128 -> each product 16384, sum 65536 wraps to 0x0000.
- Reset mid-operation: assert RESET during LOAD with 1 beat and 2 vectors in flight -> no out_valid afterwards, w_loaded=0, active weights are 0 (a new vector yields sum 0).
